// File: rtl/video_timing_meter_if.sv
// Sampled video bus from the pattern generator toward the video output.
// The pattern generator drives it as master; the timing meter observes it as slave.
interface video_timing_meter_if;
  logic       ce_pix;
  logic       hsync;
  logic       vsync;
  logic       hblank;
  logic       vblank;
  logic [7:0] video_r;
  logic [7:0] video_g;
  logic [7:0] video_b;

  modport master (output ce_pix, hsync, vsync, hblank, vblank, video_r, video_g, video_b);
  modport slave  (input  ce_pix, hsync, vsync, hblank, vblank, video_r, video_g, video_b);
endinterface

// File: rtl/video_timing_meter.sv
// Passive per-frame video timing measurement: line/sync/active geometry, pixel checksum,
// stability tracking and a no-signal timeout.
module video_timing_meter #(
  parameter int W             = 12,
  parameter int STABLE_FRAMES = 4,
  parameter int TIMEOUT       = 1048576
) (
  input  logic                 clk,
  input  logic                 reset_n,
  video_timing_meter_if.slave  vid,
  output logic [W-1:0]         h_total,
  output logic [W-1:0]         h_active,
  output logic [W-1:0]         hs_width,
  output logic [W-1:0]         v_total,
  output logic [W-1:0]         v_active,
  output logic [W-1:0]         vs_width,
  output logic [31:0]          checksum,
  output logic                 frame_done,
  output logic                 valid,
  output logic                 stable,
  output logic                 no_signal
);
  localparam logic [W-1:0] CNT_MAX = '1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int MW = $clog2(STABLE_FRAMES + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] TO_END  = TW'(TIMEOUT);
  localparam logic [MW-1:0] MATCH_MAX = MW'(STABLE_FRAMES);

  function automatic logic [W-1:0] sat_inc(input logic [W-1:0] x);
    return (x == CNT_MAX) ? x : x + W'(1);
  endfunction

  logic          sample, active, hs_rise, vs_rise, fire;
  logic [31:0]   pix;
  logic          hs_q, vs_q;
  logic [W-1:0]  h_cnt, hs_cnt, h_act, h_cnt_last, hs_last;
  logic          line_act;
  logic [W-1:0]  h_max, v_cnt, va_cnt, vs_cnt;
  logic [31:0]   sum;
  logic [W-1:0]  h_last_cl, hs_last_cl, h_max_cl, va_cl;

  logic          armed, pend;
  logic [TW-1:0] to_cnt;
  logic [W-1:0]  snap_h_total, snap_h_active, snap_hs_width;
  logic [W-1:0]  snap_v_total, snap_v_active, snap_vs_width;
  logic [31:0]   snap_sum;

  logic          have_prev, same;
  logic [MW-1:0] match_cnt, match_nxt;

  // The "_cl" values fold a line that closes on this sample into the running frame,
  // so a frame edge on the same sample still sees that line in the old frame.
  always_comb begin
    sample     = vid.ce_pix;
    active     = ~vid.hblank & ~vid.vblank;
    hs_rise    = sample & vid.hsync & ~hs_q;
    vs_rise    = sample & vid.vsync & ~vs_q;
    pix        = {8'd0, vid.video_r, vid.video_g, vid.video_b};
    h_last_cl  = hs_rise ? h_cnt : h_cnt_last;
    hs_last_cl = hs_rise ? hs_cnt : hs_last;
    h_max_cl   = (hs_rise && (h_act > h_max)) ? h_act : h_max;
    va_cl      = (hs_rise && line_act) ? sat_inc(va_cnt) : va_cnt;
    fire       = (to_cnt == TO_LAST) & ~hs_rise;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hs_q       <= 1'b0;
      vs_q       <= 1'b0;
      h_cnt      <= '0;
      hs_cnt     <= '0;
      h_act      <= '0;
      line_act   <= 1'b0;
      h_cnt_last <= '0;
      hs_last    <= '0;
      h_max      <= '0;
      v_cnt      <= '0;
      va_cnt     <= '0;
      vs_cnt     <= '0;
      sum        <= '0;
    end else if (sample) begin
      hs_q <= vid.hsync;
      vs_q <= vid.vsync;
      if (hs_rise) begin
        h_cnt      <= W'(1);
        hs_cnt     <= W'(1);
        h_act      <= active ? W'(1) : '0;
        line_act   <= active;
        h_cnt_last <= h_cnt;
        hs_last    <= hs_cnt;
      end else begin
        h_cnt <= sat_inc(h_cnt);
        if (vid.hsync) hs_cnt <= sat_inc(hs_cnt);
        if (active) begin
          h_act    <= sat_inc(h_act);
          line_act <= 1'b1;
        end
      end
      // A coincident line start becomes line 1 of the new frame.
      if (vs_rise) begin
        h_max  <= '0;
        va_cnt <= '0;
        v_cnt  <= hs_rise ? W'(1) : '0;
        vs_cnt <= hs_rise ? W'(1) : '0;
        sum    <= active ? pix : '0;
      end else begin
        h_max  <= h_max_cl;
        va_cnt <= va_cl;
        if (hs_rise) begin
          v_cnt <= sat_inc(v_cnt);
          if (vid.vsync) vs_cnt <= sat_inc(vs_cnt);
        end
        if (active) sum <= sum + pix;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      armed         <= 1'b0;
      pend          <= 1'b0;
      to_cnt        <= '0;
      no_signal     <= 1'b0;
      snap_h_total  <= '0;
      snap_h_active <= '0;
      snap_hs_width <= '0;
      snap_v_total  <= '0;
      snap_v_active <= '0;
      snap_vs_width <= '0;
      snap_sum      <= '0;
    end else begin
      pend <= 1'b0;
      if (hs_rise) begin
        to_cnt    <= '0;
        no_signal <= 1'b0;
      end else if (to_cnt != TO_END) begin
        to_cnt <= to_cnt + TW'(1);
      end
      if (vs_rise) begin
        armed <= 1'b1;
        if (armed) begin
          pend          <= 1'b1;
          snap_h_total  <= h_last_cl;
          snap_h_active <= h_max_cl;
          snap_hs_width <= hs_last_cl;
          snap_v_total  <= v_cnt;
          snap_v_active <= va_cl;
          snap_vs_width <= vs_cnt;
          snap_sum      <= sum;
        end
      end
      if (fire) begin
        armed     <= 1'b0;
        pend      <= 1'b0;
        no_signal <= 1'b1;
      end
    end
  end

  always_comb begin
    same = ({snap_h_total, snap_h_active, snap_v_total, snap_v_active} ==
            {h_total, h_active, v_total, v_active});
    match_nxt = '0;
    if (have_prev && same)
      match_nxt = (match_cnt == MATCH_MAX) ? match_cnt : match_cnt + MW'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      h_total    <= '0;
      h_active   <= '0;
      hs_width   <= '0;
      v_total    <= '0;
      v_active   <= '0;
      vs_width   <= '0;
      checksum   <= '0;
      frame_done <= 1'b0;
      valid      <= 1'b0;
      stable     <= 1'b0;
      match_cnt  <= '0;
      have_prev  <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (fire) begin
        valid     <= 1'b0;
        stable    <= 1'b0;
        match_cnt <= '0;
        have_prev <= 1'b0;
      end else if (pend) begin
        h_total    <= snap_h_total;
        h_active   <= snap_h_active;
        hs_width   <= snap_hs_width;
        v_total    <= snap_v_total;
        v_active   <= snap_v_active;
        vs_width   <= snap_vs_width;
        checksum   <= snap_sum;
        frame_done <= 1'b1;
        valid      <= 1'b1;
        have_prev  <= 1'b1;
        match_cnt  <= match_nxt;
        stable     <= (match_nxt >= MATCH_MAX);
      end
    end
  end
endmodule

// File: tb/tb_video_timing_meter.sv
// Scoreboard bench for video_timing_meter: a scaled-down raster (20x10 lines, 12x6 active)
// is streamed; expected latches are queued and checked by a monitor on each frame_done.
module tb_video_timing_meter;
  localparam int W  = 12;
  localparam int SF = 4;
  localparam int TO = 8192;
  localparam logic [23:0] RGB = 24'h010203;
  localparam logic [31:0] CS  = 32'd4755672;  // 72 active pixels * 0x010203

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [W-1:0]  h_total, h_active, hs_width, v_total, v_active, vs_width;
  logic [31:0]   checksum;
  logic          frame_done, valid, stable, no_signal;

  video_timing_meter_if vif ();

  video_timing_meter #(.W(W), .STABLE_FRAMES(SF), .TIMEOUT(TO)) dut (
    .clk(clk), .reset_n(reset_n), .vid(vif),
    .h_total(h_total), .h_active(h_active), .hs_width(hs_width),
    .v_total(v_total), .v_active(v_active), .vs_width(vs_width),
    .checksum(checksum), .frame_done(frame_done), .valid(valid),
    .stable(stable), .no_signal(no_signal)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          ht;
    int          vt;
    logic [31:0] cs;
    bit          st;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   passes = 0;
  bit   fd_prev = 1'b0;

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act == req) passes++;
    else $display("FAIL %s: got %0d, required %0d", name, act, req);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (fd_prev) chk("frame_done_width", frame_done, 0);
    fd_prev = frame_done;
    if (frame_done) begin
      if (exp_q.size() == 0) begin
        chk("frame_done_expected", exp_q.size(), 1);
      end else begin
        e = exp_q.pop_front();
        chk("h_total",  h_total,  e.ht);
        chk("h_active", h_active, 12);
        chk("hs_width", hs_width, 4);
        chk("v_total",  v_total,  e.vt);
        chk("v_active", v_active, 6);
        chk("vs_width", vs_width, 2);
        chk("checksum", checksum, e.cs);
        chk("stable",   stable,   e.st);
        chk("valid",    valid,    1);
      end
    end
  end

  task automatic push(input int ht, input int vt, input logic [31:0] cs, input bit st);
    exp_t e;
    e.ht = ht; e.vt = vt; e.cs = cs; e.st = st;
    exp_q.push_back(e);
  endtask

  // Between samples the syncs are inverted and RGB scrambled; the DUT must ignore them.
  task automatic sample(input logic hs, input logic vs, input logic hb, input logic vb,
                        input logic [23:0] rgb, input int gap);
    @(negedge clk);
    vif.ce_pix = 1'b1; vif.hsync = hs; vif.vsync = vs; vif.hblank = hb; vif.vblank = vb;
    {vif.video_r, vif.video_g, vif.video_b} = rgb;
    for (int g = 1; g < gap; g++) begin
      @(negedge clk);
      vif.ce_pix = 1'b0; vif.hsync = ~hs; vif.vsync = ~vs; vif.hblank = ~hb; vif.vblank = ~vb;
      vif.video_r = 8'($urandom); vif.video_g = 8'($urandom); vif.video_b = 8'($urandom);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      vif.ce_pix = 1'b0; vif.hsync = 1'b0; vif.vsync = 1'b0;
    end
  endtask

  // 10 lines, hsync 4 samples, active samples 6..17 on lines 4..9, vsync spans 2 line starts.
  // Non-coincident frames raise vsync at sample 5 of line 0; coincident ones at sample 0.
  task automatic frame(input int htot, input int last_len, input logic [23:0] rgb,
                       input bit coinc, input int gap, input int nlines);
    int  vs_at;
    int  len;
    logic hs, vs, hb, vb;
    vs_at = coinc ? 0 : 5;
    for (int line = 0; line < nlines; line++) begin
      len = (line == 9) ? last_len : htot;
      for (int i = 0; i < len; i++) begin
        hs = (i < 4);
        vs = (line == 0 && i >= vs_at) || (line == 1) || (line == 2 && i < vs_at);
        vb = !(line >= 4 && line < 10);
        hb = !(i >= 6 && i < 18);
        sample(hs, vs, hb, vb, rgb, gap);
      end
    end
  endtask

  initial begin
    vif.ce_pix = 1'b0; vif.hsync = 1'b0; vif.vsync = 1'b0;
    vif.hblank = 1'b1; vif.vblank = 1'b1;
    vif.video_r = 8'd0; vif.video_g = 8'd0; vif.video_b = 8'd0;
    repeat (3) @(negedge clk);
    chk("reset_h_total", h_total, 0);
    chk("reset_checksum", checksum, 0);
    chk("reset_valid", valid, 0);
    chk("reset_no_signal", no_signal, 0);
    reset_n = 1'b1;
    idle(5);

    // Arm on edge 1, first latch on edge 2, stable from edge 6.
    for (int f = 1; f <= 5; f++) begin
      frame(20, 20, RGB, 1'b0, 4, 10);
      push(20, 10, CS, f == 5);
    end
    frame(21, 21, RGB, 1'b0, 4, 10);
    push(21, 10, CS, 1'b0);
    frame(20, 20, 24'h0, 1'b0, 4, 10);
    push(20, 10, 32'd0, 1'b0);
    for (int f = 8; f <= 11; f++) begin
      frame(20, 20, RGB, 1'b0, 4, 10);
      push(20, 10, CS, f == 11);
    end
    frame(20, 20, RGB, 1'b0, 4, 10);

    idle(TO - 200);
    chk("no_signal_early", no_signal, 0);
    idle(300);
    chk("timeout_no_signal", no_signal, 1);
    chk("timeout_valid", valid, 0);
    chk("timeout_stable", stable, 0);
    chk("timeout_h_total_hold", h_total, 20);
    chk("timeout_v_total_hold", v_total, 10);
    chk("pending_latches_timeout", exp_q.size(), 0);

    frame(20, 20, RGB, 1'b0, 4, 10);
    chk("no_signal_cleared", no_signal, 0);
    chk("valid_after_rearm", valid, 0);
    push(20, 10, CS, 1'b0);
    frame(20, 20, RGB, 1'b0, 4, 10);
    push(20, 9, CS, 1'b0);
    frame(20, 20, RGB, 1'b1, 4, 10);
    push(20, 10, CS, 1'b0);
    frame(20, 20, RGB, 1'b1, 4, 10);
    push(20, 10, CS, 1'b0);
    frame(20, 20, RGB, 1'b1, 4, 10);
    push(20, 11, CS, 1'b0);

    frame(20, 5000, RGB, 1'b0, 1, 10);
    push(4095, 10, CS, 1'b0);
    frame(20, 20, RGB, 1'b0, 4, 10);
    push(20, 10, CS, 1'b0);
    frame(20, 20, RGB, 1'b0, 4, 5);

    @(negedge clk);
    chk("valid_before_reset", valid, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_h_total", h_total, 0);
    chk("arst_h_active", h_active, 0);
    chk("arst_hs_width", hs_width, 0);
    chk("arst_v_total", v_total, 0);
    chk("arst_v_active", v_active, 0);
    chk("arst_vs_width", vs_width, 0);
    chk("arst_checksum", checksum, 0);
    chk("arst_valid", valid, 0);
    chk("arst_stable", stable, 0);
    chk("arst_no_signal", no_signal, 0);
    idle(3);
    reset_n = 1'b1;
    idle(3);

    frame(20, 20, RGB, 1'b0, 3, 10);
    push(20, 10, CS, 1'b0);
    frame(20, 20, RGB, 1'b0, 3, 10);
    idle(20);
    chk("pending_latches_end", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #10000000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d passed", passes, checks);
    $fatal(1);
  end
endmodule
